spi_slave_le: RTL

- SPI peripheral (target) that receives 8- or 16-bit frames and returns data to an external SPI master.
- Pin-level counterpart of the team's SPI master. It uses the same wire format: SCK idles low, MOSI is sampled on the SCK rising edge, MISO changes on the SCK falling edge, bytes go MSB-first, and the low byte of a 16-bit word is sent first.
- Sits on the J1a I/O bus. The CPU writes a reply word, then reads the received word after the master deasserts SS_N.

---
 rtl/spi_slave_le.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_le.sv
// SPI target: 8/16-bit frames, low byte on the wire first, MSB-first within each byte.
// The CPU loads a reply word and collects the received word after SS_N rises.
module spi_slave_le #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [15:0] FILL        = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [15:0] tx,
   output logic        tx_ready,
   output logic [15:0] rx,
   output logic        rx_len,
   output logic        rx_valid,
   output logic        rx_full,
   input  logic        rx_rd,
   output logic        overrun,
   output logic        frame_err,
   output logic        active,
   input  logic        SS_N,
   input  logic        SCK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_OE
);

   typedef enum logic [1:0] {StArm, StIdle, StShift, StDone} state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sck_dly_q, ss_dly_q;
   logic                   sck_s, ss_s, mosi_s;
   logic                   sck_rise, sck_fall, ss_rise, ss_fall;

   logic [15:0] shift_in_q, shift_in_d, shift_out_q, shift_out_d;
   logic [4:0]  bitcnt_q, bitcnt_d;
   logic [15:0] buf_q, buf_d;
   logic        buf_full_q, buf_full_d;
   logic [15:0] rx_q, rx_d;
   logic        rx_len_q, rx_len_d, rx_valid_q, rx_valid_d;
   logic        rx_full_q, rx_full_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic        load, complete;

   // SS_N synchronizer resets low so ARM only leaves once the pin is really seen high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_q  <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_dly_q   <= 1'b0;
         ss_dly_q    <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_N};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         sck_dly_q   <= sck_s;
         ss_dly_q    <= ss_s;
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_dly_q;
   assign sck_fall = ~sck_s & sck_dly_q;
   assign ss_rise  = ss_s & ~ss_dly_q;
   assign ss_fall  = ~ss_s & ss_dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StArm;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         bitcnt_q    <= '0;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         rx_q        <= '0;
         rx_len_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_full_q   <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         bitcnt_q    <= bitcnt_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         rx_q        <= rx_d;
         rx_len_q    <= rx_len_d;
         rx_valid_q  <= rx_valid_d;
         rx_full_q   <= rx_full_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      bitcnt_d    = bitcnt_q;
      rx_d        = rx_q;
      rx_len_d    = rx_len_q;
      rx_valid_d  = 1'b0;
      rx_full_d   = rx_full_q;
      overrun_d   = overrun_q;
      frame_err_d = 1'b0;
      load        = 1'b0;
      complete    = 1'b0;

      // A read seen while rx_valid is high loses to the completion that raised it.
      if (rx_rd && !rx_valid_q) begin
         rx_full_d = 1'b0;
         overrun_d = 1'b0;
      end

      case (state_q)
         StArm: begin
            if (ss_s) state_d = StIdle;
         end
         StIdle: begin
            if (ss_fall) begin
               shift_out_d = buf_full_q ? {buf_q[7:0], buf_q[15:8]} : {FILL[7:0], FILL[15:8]};
               load        = 1'b1;
               shift_in_d  = '0;
               bitcnt_d    = '0;
               state_d     = StShift;
            end
         end
         StShift: begin
            if (sck_rise) begin
               if (bitcnt_q < 5'd16) begin
                  shift_in_d = {shift_in_q[14:0], mosi_s};
                  bitcnt_d   = bitcnt_q + 5'd1;
               end else begin
                  bitcnt_d = 5'd17;
               end
            end
            if (sck_fall && bitcnt_q >= 5'd1 && bitcnt_q <= 5'd15) begin
               shift_out_d = {shift_out_q[14:0], 1'b0};
            end
            if (ss_rise) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            if (bitcnt_q == 5'd16) begin
               rx_d     = {shift_in_q[7:0], shift_in_q[15:8]};
               rx_len_d = 1'b1;
               complete = 1'b1;
            end else if (bitcnt_q == 5'd8) begin
               rx_d     = {8'h00, shift_in_q[7:0]};
               rx_len_d = 1'b0;
               complete = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = StArm;
      endcase

      if (complete) begin
         rx_valid_d = 1'b1;
         rx_full_d  = 1'b1;
         overrun_d  = overrun_q | rx_full_q;
      end

      // A write coinciding with the frame start stays buffered for the next frame.
      buf_d      = we ? tx : buf_q;
      buf_full_d = we | (buf_full_q & ~load);
   end

   assign tx_ready  = ~buf_full_q;
   assign rx        = rx_q;
   assign rx_len    = rx_len_q;
   assign rx_valid  = rx_valid_q;
   assign rx_full   = rx_full_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign active    = (state_q == StShift);
   assign MISO_OE   = ~ss_s & (state_q != StArm);
   assign MISO      = shift_out_q[15] & MISO_OE;

endmodule
